// File: rtl/load_store_unit.sv
// Load/store unit: one single-beat Wishbone-style data-bus access per EX request.
// Define LSU_MISALIGN_EXC_EN to trap misaligned H/W accesses instead of aligning them down.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [2:0]        lsu_funct3_i,
    input  logic [31:0]       lsu_addr_i,
    input  logic [31:0]       lsu_wdata_i,
    output logic              lsu_stall_o,
    output logic              lsu_done_o,
    output logic [31:0]       lsu_rdata_o,
    output logic              lsu_err_o,
    output logic              lsu_exc_load_o,
    output logic              lsu_exc_store_o,
    output logic [31:0]       lsu_exc_addr_o,
    output logic [ADDR_W-1:0] dbus_addr_o,
    output logic [31:0]       dbus_dat_o,
    output logic [3:0]        dbus_sel_o,
    output logic              dbus_we_o,
    output logic              dbus_cyc_o,
    output logic              dbus_stb_o,
    input  logic [31:0]       dbus_dat_i,
    input  logic              dbus_ack_i,
    input  logic              dbus_err_i
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [3:0]  sel_q;
    logic        abort_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        bus_end;
    logic        req_exc;
    logic [3:0]  st_sel;
    logic [31:0] st_dat;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ld_ext;

    assign accept  = (state_q == IDLE) && lsu_req_i && !flush_i;
    assign bus_end = dbus_ack_i || dbus_err_i;

    // Store lane steering; funct3[1:0] alone selects the width (011/11x fall to word).
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        st_sel = 4'b1111;
        st_dat = lsu_wdata_i;
        case (lsu_funct3_i[1:0])
            2'b00: begin
                st_sel = 4'b0001 << lsu_addr_i[1:0];
                st_dat = {4{lsu_wdata_i[7:0]}};
            end
            2'b01: begin
                st_sel = 4'b0011 << {lsu_addr_i[1], 1'b0};
                st_dat = {2{lsu_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_v = 8'(dbus_dat_i >> {addr_q[1:0], 3'b000});
        half_v = 16'(dbus_dat_i >> {addr_q[1], 4'b0000});
        case (funct3_q[1:0])
            2'b00:   ld_ext = funct3_q[2] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            2'b01:   ld_ext = funct3_q[2] ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            default: ld_ext = dbus_dat_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        lsu_stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                lsu_stall_o = lsu_req_i && !flush_i;
                if (accept) state_d = req_exc ? DONE : BUSY;
            end
            BUSY: begin
                lsu_stall_o = 1'b1;
                // A flush arriving together with the termination still aborts.
                if (bus_end) state_d = (abort_q || flush_i) ? IDLE : DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        // NOTE: sequential state is updated with non-blocking assignments only.
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q   <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            sel_q    <= '0;
            abort_q  <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q   <= lsu_addr_i;
                        funct3_q <= lsu_funct3_i;
                        we_q     <= lsu_we_i;
                        wdata_q  <= st_dat;
                        sel_q    <= st_sel;
                        abort_q  <= 1'b0;
                    end
                end
                BUSY: begin
                    if (flush_i) abort_q <= 1'b1;
                    if (bus_end && !(abort_q || flush_i)) begin
                        rdata_q <= dbus_err_i ? 32'b0 : ld_ext;
                        err_q   <= dbus_err_i;
                    end
                end
                DONE: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef LSU_MISALIGN_EXC_EN
    logic        misaligned;
    logic        exc_load_q;
    logic        exc_store_q;
    logic [31:0] exc_addr_q;

    assign misaligned = ((lsu_funct3_i[1:0] == 2'b01) && lsu_addr_i[0]) ||
                        (lsu_funct3_i[1] && (lsu_addr_i[1:0] != 2'b00));
    assign req_exc    = misaligned;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exc_load_q  <= 1'b0;
            exc_store_q <= 1'b0;
            exc_addr_q  <= '0;
        end else if (accept && misaligned) begin
            exc_load_q  <= !lsu_we_i;
            exc_store_q <= lsu_we_i;
            exc_addr_q  <= lsu_addr_i;
        end else if (state_q == DONE) begin
            exc_load_q  <= 1'b0;
            exc_store_q <= 1'b0;
            exc_addr_q  <= '0;
        end
    end

    assign lsu_exc_load_o  = exc_load_q;
    assign lsu_exc_store_o = exc_store_q;
    assign lsu_exc_addr_o  = exc_addr_q;
`else
    assign req_exc         = 1'b0;
    assign lsu_exc_load_o  = 1'b0;
    assign lsu_exc_store_o = 1'b0;
    assign lsu_exc_addr_o  = '0;
`endif

    assign lsu_done_o  = (state_q == DONE);
    assign lsu_rdata_o = rdata_q;
    assign lsu_err_o   = err_q;

    assign dbus_cyc_o  = (state_q == BUSY);
    assign dbus_stb_o  = (state_q == BUSY);
    assign dbus_we_o   = we_q && (state_q == BUSY);
    assign dbus_sel_o  = (state_q == BUSY) ? sel_q : 4'b0000;
    assign dbus_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
    assign dbus_dat_o  = wdata_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory load/store unit between the execute and memory stages. Accepts one load or store per request from EX and runs a single-beat Wishbone-style transaction on the data bus. It stalls the pipeline while the bus is busy and returns the aligned, sign- or zero-extended load result on `lsu_rdata_o`, which feeds `mem_data_i` of the memory stage.

## Interface
Parameters:
- `ADDR_W`, default 32, data-bus byte-address width; `lsu_addr_i` is always 32 bits and the upper bits are truncated.

Ports:
- `clk_i` in 1: clock
- `rst_ni` in 1: asynchronous, active-low reset
- `flush_i` in 1: pipeline flush; kills the current request or result
- `lsu_req_i` in 1: EX holds a memory operation; held high while `lsu_stall_o`=1
- `lsu_we_i` in 1: 1 = store, 0 = load
- `lsu_funct3_i` in 3: RV32I width/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- `lsu_addr_i` in 32: effective byte address
- `lsu_wdata_i` in 32: store data, right-aligned
- `lsu_stall_o` out 1: freeze IF..EX
- `lsu_done_o` out 1: one-cycle pulse; operation finished
- `lsu_rdata_o` out 32: extended load data, valid while `lsu_done_o`=1
- `lsu_err_o` out 1: bus error on the finished operation, valid with `lsu_done_o`
- `lsu_exc_load_o` / `lsu_exc_store_o` out 1: misaligned load/store, valid with `lsu_done_o`
- `lsu_exc_addr_o` out 32: faulting address
- `dbus_addr_o` out ADDR_W: word-aligned address, bits [1:0] = 00
- `dbus_dat_o` out 32; `dbus_sel_o` out 4; `dbus_we_o`, `dbus_cyc_o`, `dbus_stb_o` out 1
- `dbus_dat_i` in 32; `dbus_ack_i`, `dbus_err_i` in 1

## Operation
- FSM states: IDLE, BUSY, DONE. Reset puts the FSM in IDLE and drives every output to 0.
- IDLE, `lsu_req_i`=1, `flush_i`=0:
  - Latch addr, funct3, we and the lane-shifted wdata.
  - Normal access: go to BUSY.
  - Misaligned access with the macro enabled: go directly to DONE with the exception flag set and no bus cycle.
- IDLE with `flush_i`=1: ignore the request.
- BUSY:
  - Drive `cyc`=`stb`=1 with addr, sel, we and dat held constant.
  - `dbus_ack_i` or `dbus_err_i` ends the cycle: drop `cyc`/`stb`, capture the extracted data (0 on error), go to DONE.
- DONE lasts exactly one cycle with `lsu_done_o`=1, then returns to IDLE.
- `lsu_stall_o` = `lsu_req_i` & (state != DONE) & ~abort-free-flush. Concretely:
  - Stall is high in IDLE-with-request and throughout BUSY.
  - Stall is low in DONE.
- Store lanes:
  - SB: dat = {4{b}}, sel = 0001 << a[1:0]
  - SH: dat = {2{h}}, sel = 0011 << {a[1],0}
  - SW: sel = 1111
- Load extract:
  - Shift `dbus_dat_i` right by 8·a[1:0] (bytes) or 16·a[1] (halves).
  - LB/LH sign-extend; LBU/LHU zero-extend.
- funct3 011/110/111 are treated as a word access.
- Flush during BUSY: set an abort flag. The bus cycle still completes (it is never dropped early). On termination go to IDLE, not DONE; `lsu_done_o` stays 0 and no error or exception is reported. Stall stays high until the bus cycle terminates.
- Flush during DONE: no effect. The DONE outputs are still presented and downstream flush discards them.
- `dbus_ack_i` and `dbus_err_i` together: treated as an error.

## Timing
- Request accepted at cycle 0. `cyc`/`stb` are registered and high from cycle 1.
- An ack at cycle k (k ≥ 1) gives DONE at k+1, with `lsu_rdata_o` and `lsu_done_o` registered.
- Minimum latency is 2 cycles from request to done (zero-wait ack at cycle 1).
- Back-to-back requests: DONE → IDLE → BUSY, a one-cycle bubble between accesses.
- Misaligned access with the exception macro enabled: done at cycle 1.
- Asynchronous reset mid-BUSY: `cyc`/`stb` drop immediately and the FSM returns to IDLE.

## Configuration
- `LSU_MISALIGN_EXC_EN` defined:
  - Misaligned H (a[0]=1) or W (a[1:0]≠0) raises `lsu_exc_load_o`/`lsu_exc_store_o` with `lsu_exc_addr_o`=address.
  - No bus cycle is issued.
- Not defined:
  - Exception outputs are tied to 0.
  - Misaligned accesses are aligned down: H uses a[1] only, W ignores a[1:0].
  - The bus cycle is issued normally.

## Test plan
- LW 0x100, ack at cycle 1 with `dbus_dat_i`=0xDEADBEEF → `lsu_done_o` at cycle 2, `lsu_rdata_o`=0xDEADBEEF, stall high in cycles 0–1.
- LB 0x103 with `dbus_dat_i`=0x80FFFFFF → `lsu_rdata_o`=0xFFFFFF80; LBU at the same address → 0x00000080; LHU 0x102 → 0x000080FF.
- SH 0x206 with wdata 0x1234ABCD → `dbus_dat_o`=0xABCDABCD, `dbus_sel_o`=1100, `dbus_we_o`=1, `dbus_addr_o`=0x204.
- LW 0x300 with 3 wait states then `dbus_err_i` → `lsu_done_o`=1 at cycle 5, `lsu_err_o`=1, `lsu_rdata_o`=0.
- Flush at cycle 2 of a BUSY load, ack at cycle 3 → no `lsu_done_o`, IDLE at cycle 4, stall low at cycle 4.
- With the macro enabled, LW 0x401 → `lsu_exc_load_o`=1, `lsu_exc_addr_o`=0x401 at cycle 1, `dbus_cyc_o` never asserted. Without the macro → bus read at 0x400.
